// File: rtl/lif_pkg.sv
// Shared types and helpers for the leaky integrate-and-fire layer.
// Optional feature macro used by this codebase: LIF_LAYER_SPIKE_COUNT_EN.
package lif_pkg;

    localparam int BETA_W = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPDATE = 2'd1,
        DONE   = 2'd2
    } lif_state_e;

    // Unsigned add clamped to the largest w-bit value (w <= 32).
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b, input int w);
        logic [32:0] s;
        logic [32:0] lim;
        s   = {1'b0, a} + {1'b0, b};
        lim = (33'd1 << w) - 33'd1;
        return (s > lim) ? lim[31:0] : s[31:0];
    endfunction

endpackage

// File: rtl/lif_layer_if.sv
// Step-request / step-complete bus of the LIF layer plus state readback.
// spike_cnt exists only when LIF_LAYER_SPIKE_COUNT_EN is defined.
interface lif_layer_if #(
    parameter int N_NEURONS = 4,
    parameter int STATE_W   = 8,
    parameter int CUR_W     = 8
`ifdef LIF_LAYER_SPIKE_COUNT_EN
    ,
    parameter int CNT_W     = 8
`endif
);
    import lif_pkg::*;

    localparam int SEL_W = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;

    // A step is accepted on a rising edge where in_valid && in_ready; in_valid
    // while in_ready is low is dropped. out_valid is a one-cycle completion pulse.
    logic                 in_valid;
    logic                 in_ready;
    logic [CUR_W-1:0]     in_current;
    logic [BETA_W-1:0]    beta_shift;
    logic [STATE_W-1:0]   threshold;
    logic                 out_valid;
    logic [N_NEURONS-1:0] spikes;
    logic [SEL_W-1:0]     state_sel;
    logic [STATE_W-1:0]   state_out;
    lif_state_e           dbg_state;
`ifdef LIF_LAYER_SPIKE_COUNT_EN
    logic [CNT_W-1:0]     spike_cnt;
`endif

    modport master (
        output in_valid, in_current, beta_shift, threshold, state_sel,
`ifdef LIF_LAYER_SPIKE_COUNT_EN
        input  spike_cnt,
`endif
        input  in_ready, out_valid, spikes, state_out, dbg_state
    );

    modport slave (
        input  in_valid, in_current, beta_shift, threshold, state_sel,
`ifdef LIF_LAYER_SPIKE_COUNT_EN
        output spike_cnt,
`endif
        output in_ready, out_valid, spikes, state_out, dbg_state
    );

endinterface

// File: rtl/lif_update.sv
// Combinational single-neuron update: refractory hold, leak, saturating
// integrate and threshold fire.
module lif_update
    import lif_pkg::*;
#(
    parameter int STATE_W    = 8,
    parameter int RF_W       = 2,
    parameter int REFRAC_CYC = 2
) (
    input  logic [STATE_W-1:0] i_mem,
    input  logic [STATE_W-1:0] i_cur,
    input  logic [BETA_W-1:0]  i_beta_shift,
    input  logic [STATE_W-1:0] i_threshold,
    input  logic [RF_W-1:0]    i_refrac,
    output logic [STATE_W-1:0] o_mem,
    output logic               o_spike,
    output logic [RF_W-1:0]    o_refrac
);

    logic [STATE_W-1:0] w_leak;
    logic [STATE_W-1:0] w_sum;

    always_comb begin
        w_leak = (i_beta_shift == '0) ? '0 : (i_mem >> i_beta_shift);
        // mem - leak never underflows, so only the add can overflow.
        w_sum  = STATE_W'(sat_add(32'(i_mem - w_leak), 32'(i_cur), STATE_W));
    end

    always_comb begin
        o_mem    = '0;
        o_spike  = 1'b0;
        o_refrac = '0;
        if (i_refrac != '0) begin
            o_refrac = i_refrac - 1'b1;
        end else if (w_sum >= i_threshold) begin
            o_spike  = 1'b1;
            o_refrac = RF_W'(REFRAC_CYC);
        end else begin
            o_mem    = w_sum;
        end
    end

endmodule

// File: rtl/lif_layer.sv
// Layer of N LIF neurons updated one per clock through a shared lif_update.
// Define LIF_LAYER_SPIKE_COUNT_EN to add per-neuron saturating spike counters.
module lif_layer
    import lif_pkg::*;
#(
    parameter int N_NEURONS    = 4,
    parameter int STATE_W      = 8,
    parameter int CUR_W        = 8,
    parameter int CHAIN_WEIGHT = 128,
    parameter int REFRAC_CYC   = 2
`ifdef LIF_LAYER_SPIKE_COUNT_EN
    ,
    parameter int CNT_W        = 8
`endif
) (
    input  logic        clk,
    input  logic        rst,
    lif_layer_if.slave  bus
);

    localparam int SEL_W = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
    localparam int RF_W  = (REFRAC_CYC > 0) ? $clog2(REFRAC_CYC + 1) : 1;

    lif_state_e           r_state;
    lif_state_e           w_next_state;
    logic [SEL_W-1:0]     r_idx;
    logic [STATE_W-1:0]   r_mem    [N_NEURONS];
    logic [RF_W-1:0]      r_refrac [N_NEURONS];
    logic [CUR_W-1:0]     r_cur;
    logic [BETA_W-1:0]    r_beta;
    logic [STATE_W-1:0]   r_thr;
    logic [N_NEURONS-1:0] r_shadow;
    logic [N_NEURONS-1:0] r_spikes;

    logic [SEL_W-1:0]     w_prev_idx;
    logic                 w_last;
    logic [STATE_W-1:0]   w_in;
    logic [STATE_W-1:0]   w_mem_next;
    logic                 w_spike;
    logic [RF_W-1:0]      w_refrac_next;
    logic [N_NEURONS-1:0] w_shadow_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (bus.in_valid) w_next_state = UPDATE;
            UPDATE:  if (w_last) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    assign w_last     = (r_idx == SEL_W'(N_NEURONS - 1));
    assign w_prev_idx = r_idx - 1'b1;

    // Neuron 0 takes the external current; the rest take the chain weight
    // when their predecessor fired earlier in this same step.
    always_comb begin
        w_in = '0;
        if (r_idx == '0) begin
            w_in = STATE_W'(r_cur);
        end else if (r_shadow[w_prev_idx]) begin
            w_in = STATE_W'(CHAIN_WEIGHT);
        end
    end

    lif_update #(
        .STATE_W    (STATE_W),
        .RF_W       (RF_W),
        .REFRAC_CYC (REFRAC_CYC)
    ) u_update (
        .i_mem        (r_mem[r_idx]),
        .i_cur        (w_in),
        .i_beta_shift (r_beta),
        .i_threshold  (r_thr),
        .i_refrac     (r_refrac[r_idx]),
        .o_mem        (w_mem_next),
        .o_spike      (w_spike),
        .o_refrac     (w_refrac_next)
    );

    always_comb begin
        w_shadow_next        = r_shadow;
        w_shadow_next[r_idx] = w_spike;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx    <= '0;
            r_cur    <= '0;
            r_beta   <= '0;
            r_thr    <= '0;
            r_shadow <= '0;
            r_spikes <= '0;
            for (int i = 0; i < N_NEURONS; i++) begin
                r_mem[i]    <= '0;
                r_refrac[i] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_cur    <= bus.in_current;
                        r_beta   <= bus.beta_shift;
                        r_thr    <= bus.threshold;
                        r_idx    <= '0;
                        r_shadow <= '0;
                    end
                end
                UPDATE: begin
                    r_mem[r_idx]    <= w_mem_next;
                    r_refrac[r_idx] <= w_refrac_next;
                    r_shadow        <= w_shadow_next;
                    r_idx           <= r_idx + 1'b1;
                    // Publish the full vector so it is valid alongside out_valid.
                    if (w_last) r_spikes <= w_shadow_next;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.spikes    = r_spikes;
    assign bus.state_out = r_mem[bus.state_sel];
    assign bus.dbg_state = r_state;

`ifdef LIF_LAYER_SPIKE_COUNT_EN
    logic [CNT_W-1:0] r_cnt [N_NEURONS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_NEURONS; i++) r_cnt[i] <= '0;
        end else if (r_state == UPDATE && w_spike && r_cnt[r_idx] != '1) begin
            r_cnt[r_idx] <= r_cnt[r_idx] + 1'b1;
        end
    end

    assign bus.spike_cnt = r_cnt[bus.state_sel];
`endif

endmodule

// File: tb/tb_lif_layer.sv
// Directed bench for lif_layer: step-level behavioural model, spike scoreboard
// and hand-computed pins. Honours LIF_LAYER_SPIKE_COUNT_EN when defined.
module tb_lif_layer;
    import lif_pkg::*;

    localparam int N      = 4;
    localparam int SW     = 8;
    localparam int CW     = 8;
    localparam int CHAIN  = 128;
    localparam int REFRAC = 2;
    localparam int CNTW   = 8;
    localparam int MAXV   = (1 << SW) - 1;
    localparam int CNTMAX = (1 << CNTW) - 1;

    logic clk;
    logic rst;

    lif_layer_if #(
        .N_NEURONS (N),
        .STATE_W   (SW),
        .CUR_W     (CW)
`ifdef LIF_LAYER_SPIKE_COUNT_EN
        ,
        .CNT_W     (CNTW)
`endif
    ) bus ();

    lif_layer #(
        .N_NEURONS    (N),
        .STATE_W      (SW),
        .CUR_W        (CW),
        .CHAIN_WEIGHT (CHAIN),
        .REFRAC_CYC   (REFRAC)
`ifdef LIF_LAYER_SPIKE_COUNT_EN
        ,
        .CNT_W        (CNTW)
`endif
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not reach its end, got running expected finished");
        $fatal(1);
    end

    int n_checks = 0;
    int n_errors = 0;

    // model state
    int m_mem [N];
    int m_rf  [N];
    int m_cnt [N];
    logic [N-1:0] exp_q[$];
    logic [N-1:0] last_spikes;

    function automatic void check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_mem[i] = 0;
            m_rf[i]  = 0;
            m_cnt[i] = 0;
        end
        exp_q.delete();
        last_spikes = '0;
    endtask

    task automatic model_step(input int cur, input int beta, input int thr);
        logic [N-1:0] sp;
        int inp, leak, s;
        sp = '0;
        for (int i = 0; i < N; i++) begin
            inp = (i == 0) ? cur : (sp[i-1] ? CHAIN : 0);
            if (m_rf[i] > 0) begin
                m_rf[i]  = m_rf[i] - 1;
                m_mem[i] = 0;
            end else begin
                leak = (beta == 0) ? 0 : (m_mem[i] >> beta);
                s = m_mem[i] - leak + inp;
                if (s > MAXV) s = MAXV;
                if (s >= thr) begin
                    sp[i]    = 1'b1;
                    m_mem[i] = 0;
                    m_rf[i]  = REFRAC;
                    if (m_cnt[i] < CNTMAX) m_cnt[i] = m_cnt[i] + 1;
                end else begin
                    m_mem[i] = s;
                end
            end
        end
        exp_q.push_back(sp);
    endtask

    // scoreboard: every completion is matched, spikes hold in between
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", 1, 0);
                end else begin
                    last_spikes = exp_q.pop_front();
                    check("spikes", int'(bus.spikes), int'(last_spikes));
                end
            end else begin
                check("spikes_hold", int'(bus.spikes), int'(last_spikes));
            end
        end
    end

    // driver tasks
    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    task automatic peek(input int i, output int v);
        bus.state_sel = 2'(i);
        #1;
        v = int'(bus.state_out);
    endtask

    task automatic readback(input string tag);
        int v;
        for (int i = 0; i < N; i++) begin
            peek(i, v);
            check($sformatf("%s_mem%0d", tag, i), v, m_mem[i]);
`ifdef LIF_LAYER_SPIKE_COUNT_EN
            check($sformatf("%s_cnt%0d", tag, i), int'(bus.spike_cnt), m_cnt[i]);
`endif
        end
    endtask

    task automatic do_step(input int cur, input int beta, input int thr, input bit hold);
        int k;
        @(negedge clk);
        check("in_ready_idle", int'(bus.in_ready), 1);
        bus.in_valid   = 1'b1;
        bus.in_current = CW'(cur);
        bus.beta_shift = 3'(beta);
        bus.threshold  = SW'(thr);
        model_step(cur, beta, thr);
        @(posedge clk);
        #1;
        if (!hold) bus.in_valid = 1'b0;
        bus.in_current = CW'($urandom_range(0, 255));
        bus.beta_shift = 3'($urandom_range(0, 7));
        bus.threshold  = SW'($urandom_range(0, 255));
        k = 0;
        do begin
            @(negedge clk);
            k++;
            check("in_ready_busy", int'(bus.in_ready), 0);
        end while (!bus.out_valid && k < 20);
        check("latency", k, N + 1);
        bus.in_valid = 1'b0;
        readback("step");
        @(negedge clk);
    endtask

    initial begin
        int v;
        int fires;
        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_current = '0;
        bus.beta_shift = '0;
        bus.threshold  = '0;
        bus.state_sel  = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // 1: reset state
        @(negedge clk);
        check("rst_in_ready", int'(bus.in_ready), 1);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_spikes", int'(bus.spikes), 0);
        check("rst_state", int'(bus.dbg_state), int'(IDLE));
        readback("rst");

        // 2: integrate and leak
        do_step(100, 2, 200, 1'b0);
        peek(0, v); check("pin_s1_mem0", v, 100);
        do_step(100, 2, 200, 1'b0);
        peek(0, v); check("pin_s2_mem0", v, 175);
        do_step(100, 2, 200, 1'b0);
        check("pin_s3_spikes", int'(bus.spikes), 1);
        peek(0, v); check("pin_s3_mem0", v, 0);
        peek(1, v); check("pin_s3_mem1", v, 128);

        // 3: refractory
        do_step(100, 2, 200, 1'b0);
        peek(0, v); check("pin_s4_mem0", v, 0);
        check("pin_s4_spikes", int'(bus.spikes), 0);
        peek(1, v); check("pin_s4_mem1", v, 96);
        do_step(100, 2, 200, 1'b0);
        peek(0, v); check("pin_s5_mem0", v, 0);
        do_step(100, 2, 200, 1'b0);
        peek(0, v); check("pin_s6_mem0", v, 100);
        peek(1, v); check("pin_s6_mem1", v, 54);

        // 4: saturation
        do_reset();
        do_step(200, 0, 255, 1'b0);
        peek(0, v); check("pin_sat1_mem0", v, 200);
        do_step(200, 0, 255, 1'b0);
        check("pin_sat2_spikes", int'(bus.spikes), 1);
        peek(0, v); check("pin_sat2_mem0", v, 0);
        peek(1, v); check("pin_sat2_mem1", v, 128);

        // threshold zero: every non-refractory neuron fires
        do_reset();
        do_step(0, 0, 0, 1'b0);
        check("pin_thr0_spikes", int'(bus.spikes), 15);

        // 5a: in_valid held through a step is not queued
        do_reset();
        do_step(50, 1, 200, 1'b1);
        peek(0, v); check("pin_hold1_mem0", v, 50);
        do_step(50, 1, 200, 1'b0);
        peek(0, v); check("pin_hold2_mem0", v, 75);

        // 5b: reset while idx=2 aborts the step
        @(negedge clk);
        bus.in_valid   = 1'b1;
        bus.in_current = 8'd250;
        bus.beta_shift = 3'd0;
        bus.threshold  = 8'd10;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_in_update", int'(bus.dbg_state), int'(UPDATE));
        #2 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        @(negedge clk);
        check("abort_in_ready", int'(bus.in_ready), 1);
        check("abort_out_valid", int'(bus.out_valid), 0);
        readback("abort");
        repeat (8) @(negedge clk);

        // 6: repeated firing with refractory gaps
        do_reset();
        fires = 0;
        for (int s = 0; s < 10; s++) begin
            do_step(255, 0, 1, 1'b0);
            if (bus.spikes[0]) fires++;
        end
        check("pin_fires_n0", fires, 4);
`ifdef LIF_LAYER_SPIKE_COUNT_EN
        bus.state_sel = 2'd0;
        #1 check("pin_spike_cnt0", int'(bus.spike_cnt), 4);
`endif

        repeat (3) @(negedge clk);
        check("final_queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
